// File: rtl/fft12_pkg.sv
// Shared constants and FSM state type for the 12-bin FFT output streamer.
// Imported by the interface, bin bank and streamer top.
package fft12_pkg;

  localparam int FFT_N     = 12;
  localparam int FFT_W     = 16;
  localparam int IDX_W     = 4;
  localparam int HALF_LAST = 6;
  localparam int FULL_LAST = 11;

  typedef enum logic {
    ST_IDLE,
    ST_STREAM
  } state_t;

endpackage

// File: rtl/fft12_bin_streamer_if.sv
// Handshake bundle between FFT core, streamer and downstream consumer.
// slave: streamer view (captures y*, drives out_*); master: the environment.
interface fft12_bin_streamer_if #(
  parameter int W = 16
);
  logic         in_valid;
  logic         in_ready;
  logic         half;
  logic [W-1:0] y1r, y2r, y3r, y4r, y5r, y6r;
  logic [W-1:0] y7r, y8r, y9r, y10r, y11r, y12r;
  logic [W-1:0] y1i, y2i, y3i, y4i, y5i, y6i;
  logic [W-1:0] y7i, y8i, y9i, y10i, y11i, y12i;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_re;
  logic [W-1:0] out_im;
  logic [3:0]   out_idx;
  logic         out_last;

  modport slave (
    input  in_valid, half, out_ready,
    input  y1r, y2r, y3r, y4r, y5r, y6r,
    input  y7r, y8r, y9r, y10r, y11r, y12r,
    input  y1i, y2i, y3i, y4i, y5i, y6i,
    input  y7i, y8i, y9i, y10i, y11i, y12i,
    output in_ready, out_valid, out_re,
    output out_im, out_idx, out_last
  );

  modport master (
    output in_valid, half, out_ready,
    output y1r, y2r, y3r, y4r, y5r, y6r,
    output y7r, y8r, y9r, y10r, y11r, y12r,
    output y1i, y2i, y3i, y4i, y5i, y6i,
    output y7i, y8i, y9i, y10i, y11i, y12i,
    input  in_ready, out_valid, out_re,
    input  out_im, out_idx, out_last
  );
endinterface

// File: rtl/fft12_bin_bank.sv
// N x (re,im) register file: whole-frame capture on cap_en, sync clear.
// Ports: clk, rst, cap_en, wr_re/wr_im (packed bins), idx -> rd_re/rd_im.
module fft12_bin_bank
  import fft12_pkg::*;
#(
  parameter int W = FFT_W,
  parameter int N = FFT_N
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cap_en,
  input  logic [N-1:0][W-1:0] wr_re,
  input  logic [N-1:0][W-1:0] wr_im,
  input  logic [IDX_W-1:0]    idx,
  output logic [W-1:0]        rd_re,
  output logic [W-1:0]        rd_im
);

  logic [N-1:0][W-1:0] re_q, re_d;
  logic [N-1:0][W-1:0] im_q, im_d;

  always_comb begin
    re_d = re_q;
    im_d = im_q;
    if (cap_en) begin
      re_d = wr_re;
      im_d = wr_im;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      re_q <= '0;
      im_q <= '0;
    end else begin
      re_q <= re_d;
      im_q <= im_d;
    end
  end

  // Out-of-range indices read as zero.
  always_comb begin
    rd_re = '0;
    rd_im = '0;
    if (int'(idx) < N) begin
      rd_re = re_q[idx];
      rd_im = im_q[idx];
    end
  end

endmodule

// File: rtl/fft12_bin_streamer.sv
// Captures 12 parallel FFT bins and streams them one per beat with index.
// Ports: clk, rst, bus (slave modport of fft12_bin_streamer_if), drop_cnt.
module fft12_bin_streamer
  import fft12_pkg::*;
#(
  parameter int W = FFT_W,
  parameter int N = FFT_N
) (
  input  logic                  clk,
  input  logic                  rst,
  fft12_bin_streamer_if.slave   bus,
  output logic [7:0]            drop_cnt
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               half_q, half_d;
  logic [7:0]         drop_q, drop_d;
  logic               cap_en;
  logic [IDX_W-1:0]   last_idx;
  logic [N-1:0][W-1:0] wr_re, wr_im;
  logic [W-1:0]       rd_re, rd_im;

  assign wr_re = {bus.y12r, bus.y11r, bus.y10r, bus.y9r,
                  bus.y8r, bus.y7r, bus.y6r, bus.y5r,
                  bus.y4r, bus.y3r, bus.y2r, bus.y1r};
  assign wr_im = {bus.y12i, bus.y11i, bus.y10i, bus.y9i,
                  bus.y8i, bus.y7i, bus.y6i, bus.y5i,
                  bus.y4i, bus.y3i, bus.y2i, bus.y1i};

  fft12_bin_bank #(
    .W(W),
    .N(N)
  ) u_bank (
    .clk    (clk),
    .rst    (rst),
    .cap_en (cap_en),
    .wr_re  (wr_re),
    .wr_im  (wr_im),
    .idx    (idx_q),
    .rd_re  (rd_re),
    .rd_im  (rd_im)
  );

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    half_d   = half_q;
    drop_d   = drop_q;
    cap_en   = 1'b0;
    last_idx = half_q ? IDX_W'(HALF_LAST)
                      : IDX_W'(FULL_LAST);
    unique case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          cap_en  = 1'b1;
          half_d  = bus.half;
          idx_d   = '0;
          state_d = ST_STREAM;
        end
      end
      ST_STREAM: begin
        // Offers while busy are counted, never captured.
        if (bus.in_valid && drop_q != 8'hFF)
          drop_d = drop_q + 8'd1;
        if (bus.out_ready) begin
          if (idx_q == last_idx) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      half_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      half_q  <= half_d;
      drop_q  <= drop_d;
    end
  end

  logic streaming;
  assign streaming     = (state_q == ST_STREAM);
  assign bus.in_ready  = (state_q == ST_IDLE) && !rst;
  assign bus.out_valid = streaming;
  assign bus.out_re    = streaming ? rd_re : '0;
  assign bus.out_im    = streaming ? rd_im : '0;
  assign bus.out_idx   = streaming ? idx_q : '0;
  assign bus.out_last  = streaming && (idx_q == last_idx);
  assign drop_cnt      = drop_q;

endmodule

// File: doc/fft12_bin_streamer.md
# fft12_bin_streamer

Output-side companion to `cbaFFT12`. It captures the twelve parallel complex bins produced by the combinational 12-point FFT in one cycle, then streams them out one bin per beat over a valid/ready interface, tagged with the bin index. A half-spectrum mode emits only bins 0..6, because bins 7..11 of a real-input frame are conjugates of bins 5..1. The block sits between the FFT core and any downstream consumer, such as a magnitude unit, FIFO or host port.

## Interface
- `W`, 16: bin component width, two's complement.
- `N`, 12: bins per frame. Fixed at 12; the parameter exists for package consistency only.
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: the FFT outputs are stable and the frame is offered.
- `in_ready` output 1: the block can capture a frame. High only in IDLE.
- `half` input 1: sampled at capture. 1 means emit bins 0..6; 0 means emit bins 0..11.
- `y1r`..`y12r` input W each: real part of bins 0..11 (`y1r` is bin 0).
- `y1i`..`y12i` input W each: imaginary part of bins 0..11.
- `out_valid` output 1: the current beat is valid.
- `out_ready` input 1: the consumer accepts the beat.
- `out_re`, `out_im` output W each: the current bin, passed through bit-exact.
- `out_idx` output 4: index of the current bin, 0..11.
- `out_last` output 1: high on the final beat of the frame (index 11, or 6 when `half` is set).
- `drop_cnt` output 8: saturating count of frames offered while the block was busy.

## Operation
- FSM states:
  - IDLE: `in_ready`=1.
  - STREAM: `out_valid`=1.
- In IDLE, when `in_valid`=1:
  - All 24 input words are registered into the bin bank.
  - `half` is latched and `idx` is cleared to 0.
  - The FSM moves to STREAM.
- In STREAM, each cycle with `out_valid`&`out_ready`:
  - If `idx` equals `last_idx`, the FSM returns to IDLE.
  - Otherwise `idx` increments.
  - `last_idx` is 6 when the latched `half` is 1, else 11.
- `out_valid`=1 with `out_ready`=0 is a stall. `out_re`, `out_im`, `out_idx` and `out_last` hold unchanged, and `out_valid` never drops mid-frame.
- `out_re`/`out_im` equal bank[`idx`]. `out_idx` equals `idx`. `out_last` = (`idx`==`last_idx`). All are forced to 0 in IDLE.
- `in_valid`=1 during STREAM:
  - The frame is ignored and the bank is untouched.
  - `drop_cnt` increments, saturating at 255.
  - This happens once per cycle in which `in_valid` is high.
- No arithmetic is applied to the data. Values are never sign-extended, rounded or modified.
- The `y*` inputs are ignored outside the capture cycle.

## Timing
- Reset values:
  - FSM is in IDLE.
  - `in_ready`=1 in the cycle after `rst` is deasserted (it is 0 while `rst` is high).
  - `out_valid`=0, `out_re`=0, `out_im`=0, `out_idx`=0, `out_last`=0.
  - `drop_cnt`=0 and `idx`=0.
  - The bank is cleared to 0.
- Latency: a capture at edge k gives the first beat (`out_valid`=1, `idx`=0) during the cycle after edge k.
- Throughput:
  - One bin per cycle while `out_ready`=1.
  - A full frame occupies 12 STREAM cycles plus 1 IDLE cycle, so the minimum frame period is 13 cycles.
  - A half frame needs 7 STREAM cycles plus 1 IDLE cycle, so the minimum period is 8 cycles.
- The last beat is accepted at edge m, and `in_ready`=1 in the cycle after edge m. There is no same-cycle re-capture.
- Reset mid-frame:
  - The stream aborts and the remaining bins are discarded.
  - All state returns to the reset values on the next edge.
  - No `out_last` is emitted.
- If `rst` and `in_valid` occur together, `rst` wins and nothing is captured.

## Structure
- Package `fft12_pkg` holds:
  - Constants `FFT_N`=12, `FFT_W`=16, `IDX_W`=4, `HALF_LAST`=6 and `FULL_LAST`=11.
  - The state enum `{ST_IDLE, ST_STREAM}`.
- One sub-module, `fft12_bin_bank`, contains:
  - The 12×2×W register file with a synchronous clear.
  - A capture-enable input.
  - A combinational read mux indexed by `idx`.
- The FSM, index counter and drop counter live in `fft12_bin_streamer`.

## Test plan
- **Full frame of vector A.**
  - Stimulus: drive the bins 14080+0i, −528+503i, −3456+222i, −2048+768i, 1408−3326i, 2576−1271i, −3840+0i, 2576+1271i, 1408+3326i, −2048−768i, −3456−222i, −528−503i, with `half`=0 and `out_ready`=1.
  - Required: 12 consecutive beats with `out_idx` 0..11 carrying exactly these values (for example −528 = 16'hFDF0), and `out_last` only on idx 11.
- **Half mode on vector B.**
  - Stimulus: bin 0 = 16384+0i, bin 1 = −434+1621i, bin 6 = 2560+0i, with `half`=1.
  - Required: 7 beats, `out_last` at idx 6 with 2560+0i, then `in_ready`=1 on the next cycle.
- **Backpressure on vector C.**
  - Stimulus: toggle `out_ready` as 1,0,0,1 repeating.
  - Required: data is stable during stalls, with no skipped or duplicated index (for example idx 1 holds −2039−1570i across both stall cycles), and the frame completes in 24 cycles.
- **Busy drop.**
  - Stimulus: hold `in_valid`=1 with vector D applied for 5 cycles during a vector-C stream.
  - Required: `drop_cnt`=5 and the vector-C output is unaltered. After 300 such cycles `drop_cnt` reads 255.
- **Reset mid-frame.**
  - Stimulus: assert `rst` at idx 4.
  - Required: next cycle `out_valid`=0, all outputs 0, `drop_cnt`=0. One cycle after `rst` is released, `in_ready`=1.
- **Back-to-back frames A then D.**
  - Stimulus: hold `in_valid` high continuously.
  - Required: D is captured exactly 13 cycles after A, D's first beat is 13568+0i, and `drop_cnt`=12 (one count per busy cycle).
